// File: rtl/hpdcache_sram_wbe_init_1rw.sv
// Single-port SRAM with per-group write enables, optional output register and a
// self-clearing init sequencer. Parity storage is enabled with HPDCACHE_SRAM_PARITY_EN.
module hpdcache_sram_wbe_init_1rw #(
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned BE_GRAN   = 8,
  parameter int unsigned DEPTH     = 2**ADDR_SIZE,
  parameter int unsigned OUT_REG   = 0,
  localparam int unsigned NGRP     = DATA_SIZE / BE_GRAN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  output logic                 ready,
  input  logic                 cs,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [NGRP-1:0]      wbe,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic                 rvalid,
  output logic [DATA_SIZE-1:0] rdata,
  output logic [NGRP-1:0]      rerr
);

  localparam int unsigned          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(DEPTH - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH_W = (ADDR_SIZE + 1)'(DEPTH);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                 state_q;
  logic [ADDR_SIZE-1:0]   cnt_q;
  logic                   ready_q;

  logic                   in_range;
  logic                   acc_wr;
  logic                   acc_rd;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       init_idx;
  logic [DATA_SIZE-1:0]   rd_word;
  logic [NGRP-1:0]        rd_err;

  logic [DATA_SIZE-1:0]   mem_q [DEPTH];

  logic                   s1_valid_q;
  logic [DATA_SIZE-1:0]   s1_data_q;
  logic [NGRP-1:0]        s1_err_q;

  // Init walks every word once; flush is only honoured once the array is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (cnt_q == LAST) begin
            state_q <= StReady;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StReady: begin
          if (flush) begin
            state_q <= StInit;
            ready_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StInit;
          ready_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign in_range = {1'b0, addr} < DEPTH_W;
  assign acc_wr   = (state_q == StReady) & cs & we & in_range;
  assign acc_rd   = (state_q == StReady) & cs & ~we;
  assign idx      = addr[IDX_W-1:0];
  assign init_idx = cnt_q[IDX_W-1:0];

  // Storage itself carries no reset; init clears it one word per cycle.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem_q[init_idx] <= '0;
    end else if (acc_wr) begin
      for (int unsigned g = 0; g < NGRP; g++) begin
        if (wbe[g]) begin
          mem_q[idx][g*BE_GRAN +: BE_GRAN] <= wdata[g*BE_GRAN +: BE_GRAN];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = mem_q[idx];
    end
  end

`ifdef HPDCACHE_SRAM_PARITY_EN
  logic [NGRP-1:0] par_q [DEPTH];
  logic [NGRP-1:0] wpar;
  logic [NGRP-1:0] rpar;

  always_comb begin
    wpar = '0;
    rpar = '0;
    for (int unsigned g = 0; g < NGRP; g++) begin
      wpar[g] = ^wdata[g*BE_GRAN +: BE_GRAN];
      rpar[g] = ^rd_word[g*BE_GRAN +: BE_GRAN];
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      par_q[init_idx] <= '0;
    end else if (acc_wr) begin
      for (int unsigned g = 0; g < NGRP; g++) begin
        if (wbe[g]) begin
          par_q[idx][g] <= wpar[g];
        end
      end
    end
  end

  always_comb begin
    rd_err = '0;
    if (in_range) begin
      rd_err = par_q[idx] ^ rpar;
    end
  end
`else
  assign rd_err = '0;
`endif

  // First read stage: data holds between reads, error is forced low when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_err_q   <= '0;
    end else begin
      s1_valid_q <= acc_rd;
      s1_err_q   <= acc_rd ? rd_err : '0;
      if (acc_rd) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                 s2_valid_q;
    logic [DATA_SIZE-1:0] s2_data_q;
    logic [NGRP-1:0]      s2_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
        s2_err_q   <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_valid_q ? s1_err_q : '0;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rvalid = s2_valid_q;
    assign rdata  = s2_data_q;
    assign rerr   = s2_err_q;
  end else begin : g_no_out_reg
    assign rvalid = s1_valid_q;
    assign rdata  = s1_data_q;
    assign rerr   = s1_err_q;
  end

endmodule

// File: tb/tb_hpdcache_sram_wbe_init_1rw.sv
// Drives two instances (latency 1 and 2) with identical stimulus and checks both
// against a word-array model with a queue of expected read returns.
module tb_hpdcache_sram_wbe_init_1rw;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned BG    = 8;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned NG    = DW / BG;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          cs    = 1'b0;
  logic          we    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [NG-1:0] wbe   = '0;
  logic [DW-1:0] wdata = '0;

  logic          ready_a, rvalid_a, ready_b, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [NG-1:0] rerr_a, rerr_b;

  always #5 clk = ~clk;

  hpdcache_sram_wbe_init_1rw #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .BE_GRAN(BG), .DEPTH(DEPTH), .OUT_REG(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready_a), .cs(cs), .we(we),
    .addr(addr), .wbe(wbe), .wdata(wdata), .rvalid(rvalid_a), .rdata(rdata_a),
    .rerr(rerr_a)
  );

  hpdcache_sram_wbe_init_1rw #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .BE_GRAN(BG), .DEPTH(DEPTH), .OUT_REG(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready_b), .cs(cs), .we(we),
    .addr(addr), .wbe(wbe), .wdata(wdata), .rvalid(rvalid_b), .rdata(rdata_b),
    .rerr(rerr_b)
  );

  typedef struct {
    longint        due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mdl_mem [DEPTH];
  int            init_left;
  longint        cyc;
  rd_t           qa[$];
  rd_t           qb[$];
  logic [DW-1:0] last_a, last_b;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    init_left = DEPTH;
  endtask

  task automatic check_outputs();
    check("ready_a", 64'(ready_a), 64'(init_left == 0));
    check("ready_b", 64'(ready_b), 64'(init_left == 0));
    if (qa.size() > 0 && qa[0].due == cyc) begin
      last_a = qa[0].data;
      void'(qa.pop_front());
      check("rvalid_a", 64'(rvalid_a), 64'd1);
    end else begin
      check("rvalid_a", 64'(rvalid_a), 64'd0);
    end
    check("rdata_a", 64'(rdata_a), 64'(last_a));
    check("rerr_a", 64'(rerr_a), 64'd0);
    if (qb.size() > 0 && qb[0].due == cyc) begin
      last_b = qb[0].data;
      void'(qb.pop_front());
      check("rvalid_b", 64'(rvalid_b), 64'd1);
    end else begin
      check("rvalid_b", 64'(rvalid_b), 64'd0);
    end
    check("rdata_b", 64'(rdata_b), 64'(last_b));
    check("rerr_b", 64'(rerr_b), 64'd0);
  endtask

  // Called at a falling edge: drive inputs, advance the model, check after the next edge.
  task automatic step(input logic f, input logic c, input logic w, input logic [AW-1:0] a,
                      input logic [NG-1:0] be, input logic [DW-1:0] d);
    logic [DW-1:0] rd;
    flush = f; cs = c; we = w; addr = a; wbe = be; wdata = d;
    if (init_left > 0) begin
      init_left--;
    end else begin
      if (c && w && a < DEPTH) begin
        for (int g = 0; g < NG; g++)
          if (be[g]) mdl_mem[a][g*BG +: BG] = d[g*BG +: BG];
      end else if (c && !w) begin
        rd = (a < DEPTH) ? mdl_mem[a] : '0;
        qa.push_back('{cyc + 1, rd});
        qb.push_back('{cyc + 2, rd});
      end
      if (f) clear_model();
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    flush = 1'b0; cs = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_ready_a", 64'(ready_a), 64'd0);
    check("rst_rvalid_b", 64'(rvalid_b), 64'd0);
    check("rst_rdata_a", 64'(rdata_a), 64'd0);
    check("rst_rdata_b", 64'(rdata_b), 64'd0);
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    cyc = 0;
    @(negedge clk);
    do_reset();
    idle(5);
    // Reset mid-init: the full init must run again from the start.
    do_reset();
    idle(DEPTH + 2);

    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, AW'(i), '0, '0);
    idle(3);

    step(1'b0, 1'b1, 1'b1, 4'd3, 4'hF, 32'hAABBCCDD);
    step(1'b0, 1'b1, 1'b1, 4'd3, 4'b0101, 32'h11223344);
    step(1'b0, 1'b1, 1'b0, 4'd3, '0, '0);
    idle(2);
    check("be_merge_a", 64'(rdata_a), 64'h0000_0000_AA22_CC44);
    check("be_merge_b", 64'(rdata_b), 64'h0000_0000_AA22_CC44);

    step(1'b0, 1'b1, 1'b1, 4'd1, 4'hF, 32'h0101_0101);
    step(1'b0, 1'b1, 1'b1, 4'd2, 4'hF, 32'h0202_0202);
    step(1'b0, 1'b1, 1'b0, 4'd1, '0, '0);
    step(1'b0, 1'b1, 1'b0, 4'd2, '0, '0);
    step(1'b0, 1'b1, 1'b0, 4'd3, '0, '0);
    idle(3);

    step(1'b0, 1'b1, 1'b1, 4'd13, 4'hF, 32'hDEADBEEF);
    step(1'b0, 1'b1, 1'b0, 4'd13, '0, '0);
    idle(2);
    check("oob_rdata_b", 64'(rdata_b), 64'd0);

    step(1'b0, 1'b1, 1'b1, 4'd7, 4'hF, 32'h5);
    step(1'b1, 1'b1, 1'b0, 4'd7, '0, '0);
    check("flush_rdata_a", 64'(rdata_a), 64'h5);
    idle(DEPTH + 1);
    step(1'b0, 1'b1, 1'b0, 4'd7, '0, '0);
    idle(2);
    check("flush_clear_a", 64'(rdata_a), 64'd0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(49) == 0), ($urandom_range(99) < 70), 1'($urandom_range(1)),
           AW'($urandom_range(15)), NG'($urandom), DW'($urandom));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
